mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
- Multi-cycle control FSM for the MIPS datapath. It is the successor to the single-cycle combinational decoder.
- It sequences every instruction through FETCH/DECODE/EXEC/MEM/WB over a shared memory port with a ready handshake.
- It adds beq and j, a parametrised ALU-op width, a memory-timeout watchdog and a sticky HALT state.
- It sits between the instruction register (opcode/funct), the ALU zero flag and the memory ready line, and it drives all datapath selects and enables.

Parameters:
- ALU_OP_W, 4, width of alu_op. ALU codes are zero-extended to this width: and=0000, or=0001, add=0010, sub=0110, slt=0111.
- MEM_TIMEOUT, 16, maximum cycles spent waiting for mem_ready in FETCH or MEM. A value of 0 disables the watchdog.

Ports:
- clk  in  1  clock; everything is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  6  IR[31:26]; valid from the DECODE cycle onward.
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completed the current access this cycle.
- pc_write  out  1  PC load enable.
- pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut (branch target), 10 = jump target.
- ir_write  out  1  IR load enable.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- reg_dst  out  1  destination register select: 1 = rd, 0 = rt.
- reg_write  out  1  register file write enable.
- mem2reg  out  1  write-back source: 1 = ALU, 0 = memory data.
- ex_top  out  1  immediate extend mode: 1 = sign-extend, 0 = zero-extend.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = register A.
- alu_src_b  out  2  ALU B select: 00 = register B, 01 = constant 4, 10 = extended immediate, 11 = extended immediate << 2.
- alu_op  out  ALU_OP_W  ALU operation.
- state  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction.
- illegal  out  1  one-cycle pulse in DECODE for an unsupported opcode/funct.
- bus_error  out  1  sticky; set on watchdog expiry.

Behaviour:
- Reset
  - rst=1 at an edge forces state=FETCH, clears the watchdog counter and clears bus_error.
  - While rst=1, every output is forced to 0. This overrides the current state, including in HALT.
  - An access in progress is abandoned when reset is asserted.
- Output default
  - Every output is 0 unless the state rules below assert it.
  - Outputs are combinational from state, the latched opcode/funct, zero and mem_ready.
- FETCH
  - Drives mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01 and alu_op=add.
  - Stays in FETCH while mem_ready=0.
  - In the cycle mem_ready=1: ir_write=1 and pc_write=1 with pc_src=00, then go to DECODE.
- DECODE
  - Latches opcode and funct into internal registers; EXEC, MEM and WB use only the latched copies.
  - Drives alu_src_a=0, alu_src_b=11, alu_op=add and ex_top=1 to precompute the branch target.
  - If the instruction is supported, go to EXEC.
  - Otherwise pulse illegal and instr_done and go to FETCH, with no register or memory write.
- Supported instructions
  - R-type with opcode 000000: add (funct 100000), sub (100010), and (100100), or (100101), slt (101010).
  - I-type: addi (001000), lw (100011), sw (101011), beq (000100).
  - Jump: j (000010).
- EXEC
  - R-type: alu_src_a=1, alu_src_b=00, alu_op from funct, then go to WB.
  - addi/lw/sw: alu_src_a=1, alu_src_b=10, ex_top=1, alu_op=add. addi goes to WB; lw and sw go to MEM.
  - beq: alu_src_a=1, alu_src_b=00, alu_op=sub, pc_src=01, pc_write=zero, pulse instr_done, then go to FETCH.
  - j: pc_src=10, pc_write=1, pulse instr_done, then go to FETCH.
- MEM
  - Drives i_or_d=1, with mem_read=1 for lw or mem_write=1 for sw.
  - The request is held, unchanged, until mem_ready=1.
  - On mem_ready: lw goes to WB; sw pulses instr_done and goes to FETCH.
- WB
  - reg_write=1 and instr_done=1, then go to FETCH.
  - R-type: reg_dst=1, mem2reg=1.
  - addi: reg_dst=0, mem2reg=1.
  - lw: reg_dst=0, mem2reg=0.
- Watchdog (active only when MEM_TIMEOUT>0)
  - The counter clears on every state change.
  - It increments on each cycle spent in FETCH or MEM with mem_ready=0.
  - If it reaches MEM_TIMEOUT-1 and mem_ready=0 in that cycle, the next state is HALT and bus_error is set.
  - If mem_ready=1 in that same final cycle, the access completes normally.
- HALT
  - All outputs except state and bus_error are 0.
  - HALT is left only by rst.
- Latency with zero-wait memory (mem_ready held at 1):
  - R-type and addi: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq and j: 3 cycles.
  - illegal: 2 cycles.
  - Each cycle of mem_ready=0 adds one cycle.

Test Plan:
1. Reset, then add (opcode 0, funct 100000) with mem_ready=1.
   - Required: state sequence 0,1,2,4,0.
   - EXEC: alu_op=0010.
   - WB: reg_write=1, reg_dst=1, mem2reg=1.
   - instr_done pulses once.
2. lw with mem_ready low for 3 cycles in MEM.
   - Required: mem_read=1 and i_or_d=1 held for 4 cycles, then WB with mem2reg=0 and reg_dst=0.
   - Total 8 cycles.
3. beq with zero=1, then beq with zero=0.
   - Required: in EXEC, pc_write=1 then 0, with pc_src=01 and alu_op=0110 both times.
   - Each instruction takes 3 cycles.
4. opcode 111111 in DECODE.
   - Required: illegal=1 for one cycle, next state FETCH.
   - reg_write and mem_write stay 0 throughout.
5. MEM_TIMEOUT=4 with mem_ready held 0 in FETCH.
   - Required: state=7 after 4 FETCH cycles, and bus_error=1.
   - bus_error stays 1 until rst, after which state=0 and bus_error=0.
6. rst asserted during MEM of sw.
   - Required: mem_write drops to 0 in the same cycle.
   - state=0 at the next edge; the next fetch proceeds normally.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over a shared
// memory port, with a memory watchdog that parks the machine in a sticky HALT.
module mips_multicycle_ctrl #(
  parameter int ALU_OP_W    = 4,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                ir_write,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                mem2reg,
  output logic                ex_top,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [2:0]          state,
  output logic                instr_done,
  output logic                illegal,
  output logic                bus_error
);

  // Memory handshake: mem_read/mem_write (with i_or_d) are held unchanged while
  // mem_ready=0; the access completes in the cycle where mem_ready=1 is sampled.

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(4'b0000);
  localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(4'b0001);
  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(4'b0010);
  localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(4'b0110);
  localparam logic [ALU_OP_W-1:0] ALU_SLT = ALU_OP_W'(4'b0111);

  localparam int WD_W      = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int WD_LAST_I = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
  localparam logic [WD_W-1:0] WD_LAST = WD_LAST_I[WD_W-1:0];

  state_t          state_q;
  logic [5:0]      op_q;
  logic [5:0]      fn_q;
  logic [WD_W-1:0] wd_cnt;
  logic            bus_err_q;
  logic            wd_expire;
  logic            dec_ok;

  function automatic logic is_supported(input logic [5:0] op, input logic [5:0] fn);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: ok = 1'b1;
          default: ok = 1'b0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [ALU_OP_W-1:0] rtype_alu(input logic [5:0] fn);
    logic [ALU_OP_W-1:0] code;
    case (fn)
      FN_SUB:  code = ALU_SUB;
      FN_AND:  code = ALU_AND;
      FN_OR:   code = ALU_OR;
      FN_SLT:  code = ALU_SLT;
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

  // Decode looks at the live IR fields; later states only trust the latched copies.
  assign dec_ok    = is_supported(opcode, funct);
  assign wd_expire = (MEM_TIMEOUT > 0) && (wd_cnt == WD_LAST) && !mem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      fn_q      <= '0;
      wd_cnt    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH, S_MEM: begin
          if (mem_ready) begin
            wd_cnt <= '0;
            if (state_q == S_FETCH)  state_q <= S_DECODE;
            else if (op_q == OP_LW)  state_q <= S_WB;
            else                     state_q <= S_FETCH;
          end else if (wd_expire) begin
            wd_cnt    <= '0;
            state_q   <= S_HALT;
            bus_err_q <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        S_DECODE: begin
          op_q    <= opcode;
          fn_q    <= funct;
          wd_cnt  <= '0;
          state_q <= dec_ok ? S_EXEC : S_FETCH;
        end
        S_EXEC: begin
          wd_cnt <= '0;
          case (op_q)
            OP_LW, OP_SW:     state_q <= S_MEM;
            OP_RTYPE, OP_ADDI: state_q <= S_WB;
            default:          state_q <= S_FETCH;
          endcase
        end
        S_WB: begin
          wd_cnt  <= '0;
          state_q <= S_FETCH;
        end
        S_HALT: state_q <= S_HALT;
        default: begin
          wd_cnt  <= '0;
          state_q <= S_FETCH;
        end
      endcase
    end
  end

  always_comb begin
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    mem2reg    = 1'b0;
    ex_top     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = '0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    state      = rst ? 3'd0 : state_q;
    bus_error  = bus_err_q && !rst;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          alu_op    = ALU_ADD;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b  = 2'b11;
          alu_op     = ALU_ADD;
          ex_top     = 1'b1;
          illegal    = !dec_ok;
          instr_done = !dec_ok;
        end
        S_EXEC: begin
          case (op_q)
            OP_RTYPE: begin
              alu_src_a = 1'b1;
              alu_op    = rtype_alu(fn_q);
            end
            OP_ADDI, OP_LW, OP_SW: begin
              alu_src_a = 1'b1;
              alu_src_b = 2'b10;
              ex_top    = 1'b1;
              alu_op    = ALU_ADD;
            end
            OP_BEQ: begin
              alu_src_a  = 1'b1;
              alu_op     = ALU_SUB;
              pc_src     = 2'b01;
              pc_write   = zero;
              instr_done = 1'b1;
            end
            OP_J: begin
              pc_src     = 2'b10;
              pc_write   = 1'b1;
              instr_done = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          i_or_d     = 1'b1;
          mem_read   = (op_q == OP_LW);
          mem_write  = (op_q == OP_SW);
          instr_done = mem_ready && (op_q == OP_SW);
        end
        S_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          reg_dst    = (op_q == OP_RTYPE);
          mem2reg    = (op_q != OP_LW);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: one default instance and one with a
// short watchdog, both driven by the same inputs.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       pc_write, ir_write, i_or_d, mem_read, mem_write, reg_dst, reg_write;
  logic       mem2reg, ex_top, alu_src_a, instr_done, illegal, bus_error;
  logic [1:0] pc_src, alu_src_b;
  logic [3:0] alu_op;
  logic [2:0] state;

  logic       w_pc_write, w_ir_write, w_i_or_d, w_mem_read, w_mem_write, w_reg_dst, w_reg_write;
  logic       w_mem2reg, w_ex_top, w_alu_src_a, w_instr_done, w_illegal, w_bus_error;
  logic [1:0] w_pc_src, w_alu_src_b;
  logic [3:0] w_alu_op;
  logic [2:0] w_state;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc;
  int done_cnt;

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .reg_dst(reg_dst), .reg_write(reg_write),
    .mem2reg(mem2reg), .ex_top(ex_top), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .state(state), .instr_done(instr_done), .illegal(illegal),
    .bus_error(bus_error)
  );

  mips_multicycle_ctrl #(.ALU_OP_W(4), .MEM_TIMEOUT(4)) dut_wd (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_write(w_pc_write), .pc_src(w_pc_src), .ir_write(w_ir_write), .i_or_d(w_i_or_d),
    .mem_read(w_mem_read), .mem_write(w_mem_write), .reg_dst(w_reg_dst), .reg_write(w_reg_write),
    .mem2reg(w_mem2reg), .ex_top(w_ex_top), .alu_src_a(w_alu_src_a), .alu_src_b(w_alu_src_b),
    .alu_op(w_alu_op), .state(w_state), .instr_done(w_instr_done), .illegal(w_illegal),
    .bus_error(w_bus_error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 2-3 ns after the edge.
  task automatic step();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic settle();
    #1;
    if (instr_done) done_cnt++;
  endtask

  function automatic logic [31:0] all_outs();
    return {13'd0, pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write, reg_dst,
            reg_write, mem2reg, ex_top, alu_src_a, alu_src_b, alu_op, instr_done, illegal};
  endfunction

  initial begin
    rst = 1'b1; opcode = 6'b0; funct = 6'b0; zero = 1'b0; mem_ready = 1'b1;
    step(); step(); #1;
    check("rst_state", state, 3'd0);
    check("rst_outs", all_outs(), 32'd0);
    check("rst_bus_error", bus_error, 1'b0);

    // Test 1: add, zero-wait memory
    rst = 1'b0; opcode = 6'b000000; funct = 6'b100000; mem_ready = 1'b1;
    cyc = 1; done_cnt = 0; settle();
    check("add_fetch_state", state, 3'd0);
    check("add_fetch_ctl", {mem_read, ir_write, pc_write, pc_src, alu_src_b, alu_op}, {3'b111, 2'b00, 2'b01, 4'b0010});
    step(); settle();
    check("add_decode_state", state, 3'd1);
    check("add_decode_ctl", {alu_src_b, ex_top, illegal}, {2'b11, 1'b1, 1'b0});
    step(); settle();
    check("add_exec_state", state, 3'd2);
    check("add_exec_ctl", {alu_src_a, alu_src_b, alu_op}, {1'b1, 2'b00, 4'b0010});
    step(); settle();
    check("add_wb_state", state, 3'd4);
    check("add_wb_ctl", {reg_write, reg_dst, mem2reg, instr_done}, 4'b1111);
    check("add_cycles", cyc, 4);
    step(); settle();
    check("add_back_fetch", state, 3'd0);
    check("add_done_pulses", done_cnt, 1);

    // Test 2: lw with 3 wait cycles in MEM (last wait cycle is the watchdog boundary for dut_wd)
    opcode = 6'b100011; funct = 6'b000000; mem_ready = 1'b1;
    cyc = 1; done_cnt = 0; settle();
    step(); settle();
    check("lw_decode_state", state, 3'd1);
    step(); settle();
    check("lw_exec_ctl", {alu_src_a, alu_src_b, ex_top, alu_op}, {1'b1, 2'b10, 1'b1, 4'b0010});
    for (int i = 0; i < 4; i++) begin
      step();
      mem_ready = (i == 3);
      settle();
      check($sformatf("lw_mem_state_%0d", i), state, 3'd3);
      check($sformatf("lw_mem_req_%0d", i), {mem_read, i_or_d, mem_write, reg_write}, 4'b1100);
    end
    step(); settle();
    check("lw_wb_state", state, 3'd4);
    check("lw_wb_ctl", {reg_write, mem2reg, reg_dst, instr_done}, 4'b1001);
    check("lw_cycles", cyc, 8);
    check("lw_wd_no_halt", {w_state, w_bus_error}, {3'd4, 1'b0});
    step(); settle();
    check("lw_done_pulses", done_cnt, 1);

    // Test 3: beq taken then not taken
    for (int z = 1; z >= 0; z--) begin
      opcode = 6'b000100; mem_ready = 1'b1; zero = z[0];
      cyc = 1; settle();
      step(); settle();
      step(); settle();
      check($sformatf("beq%0d_exec_state", z), state, 3'd2);
      check($sformatf("beq%0d_exec_ctl", z), {pc_write, pc_src, alu_op, alu_src_a, alu_src_b, instr_done},
            {z[0], 2'b01, 4'b0110, 1'b1, 2'b00, 1'b1});
      check($sformatf("beq%0d_cycles", z), cyc, 3);
      step(); settle();
      check($sformatf("beq%0d_back_fetch", z), state, 3'd0);
    end
    zero = 1'b0;

    // j: pc_src=10 in EXEC, 3 cycles
    opcode = 6'b000010; cyc = 1; settle();
    step(); settle(); step(); settle();
    check("j_exec_ctl", {state, pc_write, pc_src, instr_done}, {3'd2, 1'b1, 2'b10, 1'b1});
    step(); settle();
    check("j_back_fetch", state, 3'd0);

    // addi: WB writes rt with ALU data
    opcode = 6'b001000; settle();
    step(); settle(); step(); settle(); step(); settle();
    check("addi_wb_ctl", {state, reg_write, reg_dst, mem2reg}, {3'd4, 3'b101});
    step(); settle();

    // Test 4: unsupported opcode, and an unsupported R-type funct
    for (int k = 0; k < 2; k++) begin
      opcode = (k == 0) ? 6'b111111 : 6'b000000;
      funct  = (k == 0) ? 6'b000000 : 6'b001000;
      cyc = 1; settle();
      check($sformatf("ill%0d_fetch_writes", k), {reg_write, mem_write, illegal}, 3'b000);
      step(); settle();
      check($sformatf("ill%0d_decode", k), {state, illegal, instr_done, reg_write, mem_write}, {3'd1, 4'b1100});
      step(); settle();
      check($sformatf("ill%0d_next_fetch", k), {state, illegal, reg_write, mem_write}, {3'd0, 3'b000});
    end

    // Test 6: rst asserted during MEM of sw
    opcode = 6'b101011; funct = 6'b000000; mem_ready = 1'b1; settle();
    step(); settle(); step(); settle();
    step(); mem_ready = 1'b0; settle();
    check("sw_mem_ctl", {state, mem_write, mem_read, i_or_d}, {3'd3, 3'b101});
    rst = 1'b1; settle();
    check("sw_rst_mem_write", mem_write, 1'b0);
    step(); rst = 1'b0; mem_ready = 1'b1; opcode = 6'b000000; funct = 6'b100101; settle();
    check("sw_rst_state", state, 3'd0);
    check("refetch_ctl", {mem_read, ir_write, pc_write, i_or_d}, 4'b1110);
    step(); settle();
    check("refetch_decode", state, 3'd1);
    step(); settle();
    check("or_exec_alu", alu_op, 4'b0001);
    step(); step(); settle();

    // Test 5: watchdog expiry in FETCH (dut_wd has MEM_TIMEOUT=4)
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      check($sformatf("wd_fetch_%0d", i), {w_state, w_bus_error, w_mem_read}, {3'd0, 2'b01});
      step();
    end
    settle();
    check("wd_halt_state", w_state, 3'd7);
    check("wd_bus_error", w_bus_error, 1'b1);
    check("wd_halt_outs", {w_mem_read, w_ir_write, w_pc_write, w_alu_src_b, w_alu_op}, 11'd0);
    check("wd_long_timeout_still_fetch", {state, bus_error}, {3'd0, 1'b0});
    mem_ready = 1'b1;
    step(); step(); settle();
    check("wd_halt_sticky", {w_state, w_bus_error}, {3'd7, 1'b1});
    rst = 1'b1; settle();
    check("wd_rst_forced", {w_state, w_bus_error}, {3'd0, 1'b0});
    step(); rst = 1'b0; settle();
    check("wd_after_rst", {w_state, w_bus_error, w_mem_read}, {3'd0, 2'b01});
    step(); settle();
    check("wd_after_rst_decode", w_state, 3'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
